// File: rtl/pio_ram_link_if.sv
// Request/response bus between the renderer memory client and pio_ram_link.
//   master : memory client side (drives req_*, receives resp_*/timeout)
//   slave  : pio_ram_link side
//   req_valid/req_ready  request handshake, req_we 1=write, req_addr, req_wdata
//   resp_valid           one-cycle pulse when resp_data is updated
//   resp_data            last read word, held until the next response
//   timeout              one-cycle pulse when a read aborted without response
interface pio_ram_link_if #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_BITS = 16
) ();

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_BITS-1:0] req_addr;
  logic [DATA_BITS-1:0] req_wdata;
  logic                 resp_valid;
  logic [DATA_BITS-1:0] resp_data;
  logic                 timeout;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data, timeout
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data, timeout
  );

endinterface

// File: rtl/pio_ram_link.sv
// Serial link master to the PIO RAM emulator: serialises read/write requests
// into 2-bit symbols on tx_pins and deserialises read responses from rx_pins.
//   clk, rst_n  clock and synchronous active-low reset
//   bus         request/response bus (slave side)
//   tx_pins     registered symbol stream to the emulator (00 when idle)
//   rx_pins     symbol stream from the emulator, registered upstream
module pio_ram_link #(
  parameter int unsigned ADDR_BITS = 16,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  pio_ram_link_if.slave bus,
  output logic [1:0]  tx_pins,
  input  logic [1:0]  rx_pins
);

  localparam int unsigned A_SYMS  = ADDR_BITS / 2;
  localparam int unsigned D_SYMS  = DATA_BITS / 2;
  localparam int unsigned CNT_MAX = (A_SYMS > D_SYMS) ? A_SYMS : D_SYMS;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_ADDR, S_WDATA, S_WAIT, S_RECV, S_DONE
  } state_t;

  state_t               state;
  logic                 we_q;
  logic [ADDR_BITS-1:0] addr_sh;
  logic [DATA_BITS-1:0] wdata_sh;
  logic [DATA_BITS-1:0] rx_sh;
  logic [DATA_BITS-1:0] resp_data_q;
  logic [CNT_W-1:0]     sym_cnt;
  logic [TMO_W-1:0]     wait_cnt;
  logic                 ready_q;
  logic                 resp_valid_q;
  logic                 timeout_q;
  logic [1:0]           tx_q;

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.timeout    = timeout_q;
  assign tx_pins        = tx_q;

  // Link FSM; tx_q is loaded one edge ahead so each symbol is visible for the
  // whole cycle spent in the state that owns it. S_DONE is the common exit
  // cycle in which either resp_valid or timeout is visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      we_q         <= 1'b0;
      addr_sh      <= '0;
      wdata_sh     <= '0;
      rx_sh        <= '0;
      resp_data_q  <= '0;
      sym_cnt      <= '0;
      wait_cnt     <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      tx_q         <= 2'b00;
    end else begin
      resp_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            addr_sh  <= bus.req_addr;
            wdata_sh <= bus.req_wdata;
            tx_q     <= {1'b1, bus.req_we};
            ready_q  <= 1'b0;
            state    <= S_HDR;
          end
        end
        S_HDR: begin
          tx_q    <= addr_sh[ADDR_BITS-1 -: 2];
          addr_sh <= addr_sh << 2;
          sym_cnt <= CNT_W'(1);
          state   <= S_ADDR;
        end
        // sym_cnt holds the number of symbols already placed on tx_q
        S_ADDR: begin
          if (sym_cnt == CNT_W'(A_SYMS)) begin
            if (we_q) begin
              tx_q     <= wdata_sh[DATA_BITS-1 -: 2];
              wdata_sh <= wdata_sh << 2;
              sym_cnt  <= CNT_W'(1);
              state    <= S_WDATA;
            end else begin
              tx_q     <= 2'b00;
              wait_cnt <= '0;
              state    <= S_WAIT;
            end
          end else begin
            tx_q    <= addr_sh[ADDR_BITS-1 -: 2];
            addr_sh <= addr_sh << 2;
            sym_cnt <= sym_cnt + CNT_W'(1);
          end
        end
        S_WDATA: begin
          if (sym_cnt == CNT_W'(D_SYMS)) begin
            tx_q    <= 2'b00;
            ready_q <= 1'b1;
            state   <= S_IDLE;
          end else begin
            tx_q     <= wdata_sh[DATA_BITS-1 -: 2];
            wdata_sh <= wdata_sh << 2;
            sym_cnt  <= sym_cnt + CNT_W'(1);
          end
        end
        // Start symbol is checked before the limit so it wins in the last cycle
        S_WAIT: begin
          if (rx_pins[0]) begin
            sym_cnt <= '0;
            state   <= S_RECV;
          end else if (wait_cnt == TMO_W'(TIMEOUT - 1)) begin
            timeout_q <= 1'b1;
            state     <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + TMO_W'(1);
          end
        end
        S_RECV: begin
          rx_sh <= DATA_BITS'({rx_sh, rx_pins});
          if (sym_cnt == CNT_W'(D_SYMS - 1)) begin
            resp_data_q  <= DATA_BITS'({rx_sh, rx_pins});
            resp_valid_q <= 1'b1;
            state        <= S_DONE;
          end else begin
            sym_cnt <= sym_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          tx_q    <= 2'b00;
          ready_q <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pio_ram_link.sv
// Self-checking bench for pio_ram_link: directed scenarios plus randomized
// read/write/timeout transactions checked cycle by cycle against expectations
// computed from the link protocol (symbol k of a word, response and timeout
// cycle offsets from the request edge).
module tb_pio_ram_link;

  localparam int unsigned AB = 16;
  localparam int unsigned DB = 16;
  localparam int unsigned TO = 6;
  localparam int unsigned A  = AB / 2;
  localparam int unsigned D  = DB / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] tx_pins;
  logic [1:0] rx_pins;

  pio_ram_link_if #(.ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

  pio_ram_link #(.ADDR_BITS(AB), .DATA_BITS(DB), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .tx_pins (tx_pins),
    .rx_pins (rx_pins)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [DB-1:0] model_resp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Symbol k (MSB-first) of a word of the given width
  function automatic logic [1:0] sym_of(input logic [31:0] v, input int width, input int k);
    logic [31:0] s;
    s = (v >> (width - 2 - 2 * k)) & 32'd3;
    return s[1:0];
  endfunction

  // Advance one cycle: drive rx just after the edge, return at the mid-cycle sample point
  task automatic next_cycle(input logic [1:0] rx);
    @(posedge clk);
    #1;
    rx_pins = rx;
    @(negedge clk);
  endtask

  task automatic quiet(input string tag);
    check({tag, "_resp_valid"}, bus.resp_valid, 0);
    check({tag, "_timeout"}, bus.timeout, 0);
    check({tag, "_resp_data"}, bus.resp_data, model_resp);
  endtask

  // Issue the request header/address phase; called at a sample point with the link idle
  task automatic send_req(input bit we, input logic [AB-1:0] addr, input logic [DB-1:0] wdata);
    check("ready_idle", bus.req_ready, 1);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_addr  = AB'($urandom);
    bus.req_wdata = DB'($urandom);
    rx_pins       = 2'($urandom);
    @(negedge clk);
    check("hdr", tx_pins, {1'b1, we});
    check("busy", bus.req_ready, 0);
    quiet("hdr");
    for (int i = 0; i < int'(A); i++) begin
      next_cycle(2'($urandom));
      check("addr_sym", tx_pins, sym_of(addr, AB, i));
      quiet("addr");
    end
  endtask

  // Full transaction; start_dly = WAIT cycle carrying the start symbol (>= TO means none in window)
  task automatic do_txn(input bit we, input logic [AB-1:0] addr, input logic [DB-1:0] wdata,
                        input int start_dly, input logic [DB-1:0] rdata);
    send_req(we, addr, wdata);
    if (we) begin
      for (int i = 0; i < int'(D); i++) begin
        next_cycle(2'($urandom));
        check("wdata_sym", tx_pins, sym_of(wdata, DB, i));
        quiet("wdata");
      end
      next_cycle(2'($urandom));
      check("wr_end_tx", tx_pins, 0);
      check("wr_end_ready", bus.req_ready, 1);
      quiet("wr_end");
    end else begin
      for (int j = 0; j < int'(TO); j++) begin
        next_cycle({1'($urandom), (j == start_dly) ? 1'b1 : 1'b0});
        check("wait_tx", tx_pins, 0);
        check("wait_busy", bus.req_ready, 0);
        quiet("wait");
        if (j == start_dly) break;
      end
      if (start_dly < int'(TO)) begin
        for (int i = 0; i < int'(D); i++) begin
          next_cycle(sym_of(rdata, DB, i));
          check("recv_tx", tx_pins, 0);
          quiet("recv");
        end
        next_cycle(2'($urandom));
        check("resp_valid", bus.resp_valid, 1);
        check("resp_data", bus.resp_data, rdata);
        check("resp_no_timeout", bus.timeout, 0);
        check("resp_busy", bus.req_ready, 0);
        model_resp = rdata;
        next_cycle(2'($urandom));
        check("rd_end_ready", bus.req_ready, 1);
        quiet("rd_end");
      end else begin
        next_cycle((start_dly == int'(TO)) ? 2'b01 : {1'($urandom), 1'b0});
        check("timeout", bus.timeout, 1);
        check("timeout_no_resp", bus.resp_valid, 0);
        check("timeout_resp_held", bus.resp_data, model_resp);
        check("timeout_busy", bus.req_ready, 0);
        next_cycle(2'($urandom));
        check("to_end_ready", bus.req_ready, 1);
        quiet("to_end");
      end
    end
  endtask

  // Read that is reset partway through receiving its response
  task automatic do_abort(input logic [AB-1:0] addr, input logic [DB-1:0] rdata);
    send_req(1'b0, addr, '0);
    next_cycle(2'b01);
    check("abort_wait_tx", tx_pins, 0);
    next_cycle(sym_of(rdata, DB, 0));
    next_cycle(sym_of(rdata, DB, 1));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    rx_pins = 2'($urandom);
    @(negedge clk);
    model_resp = '0;
    check("abort_ready", bus.req_ready, 1);
    check("abort_tx", tx_pins, 0);
    quiet("abort");
    for (int i = 0; i < int'(D) + 2; i++) begin
      next_cycle(2'($urandom));
      check("abort_idle", bus.req_ready, 1);
      quiet("abort_idle");
    end
  endtask

  initial begin
    model_resp    = '0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = AB'($urandom);
    bus.req_wdata = DB'($urandom);
    rx_pins       = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_tx", tx_pins, 0);
      check("rst_ready", bus.req_ready, 1);
      quiet("rst");
    end
    rst_n         = 1'b1;
    bus.req_valid = 1'b0;
    rx_pins       = 2'b00;

    do_txn(1'b1, 16'hA5C3, 16'h1234, 0, '0);
    do_txn(1'b0, 16'h0001, '0, 5, 16'hBEEF);
    do_txn(1'b0, 16'h0F0F, '0, 0, 16'h5A5A);
    do_txn(1'b0, 16'h1357, '0, 99, 16'hFFFF);
    do_txn(1'b0, 16'h2468, '0, int'(TO), 16'h0000);
    do_txn(1'b0, 16'hFFFF, '0, int'(TO) - 1, 16'h8001);
    do_txn(1'b1, 16'h0000, 16'hFFFF, 0, '0);
    do_abort(16'hC0DE, 16'hCAFE);
    do_txn(1'b0, 16'h0042, '0, 2, 16'h7E57);

    for (int n = 0; n < 40; n++) begin
      do_txn(1'($urandom), AB'($urandom), DB'($urandom),
             int'($urandom_range(0, TO + 2)), DB'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pio_ram_link.md
# pio_ram_link

Serial link master between the Julia renderer's memory client and the external PIO RAM emulator. It turns parallel read/write requests into a 2-bit-wide symbol stream on `tx_pins` and deserialises read responses arriving on `rx_pins`. It sits inside `julia_top`, directly feeding the pad-level `tx_pins` and consuming `rx_pins`. The chip top already registers both pin buses, so the emulator delay calibration loopback during reset does not involve this block.

## Interface

Parameters:
- `ADDR_BITS`, default 16: request address width; must be even.
- `DATA_BITS`, default 16: data word width; must be even.
- `TIMEOUT`, default 255: maximum number of WAIT cycles allowed before a read aborts; must be at least 1.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block idle; a request is accepted on `req_valid && req_ready`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_BITS  word address.
- `req_wdata`  in  DATA_BITS  write data.
- `resp_valid`  out  1  one-cycle pulse: `resp_data` is updated.
- `resp_data`  out  DATA_BITS  last read word; held until the next response.
- `timeout`  out  1  one-cycle pulse: a read was aborted with no response.
- `tx_pins`  out  2  symbol stream to the emulator.
- `rx_pins`  in  2  symbol stream from the emulator (already registered upstream).

## Operation

- States: IDLE, HDR, ADDR, WDATA, WAIT, RECV, DONE.
- `req_ready` = (state == IDLE). All inputs are captured into internal registers on acceptance. `req_*` are don't-care at all other times.
- TX symbols:
  - `tx_pins` is registered and equals 2'b00 whenever no symbol is being driven.
  - The header symbol is {1'b1, we}.
  - The address follows, MSB-first, 2 bits per cycle, for ADDR_BITS/2 symbols.
  - For a write, the data follows, MSB-first, for DATA_BITS/2 symbols.
- Write path: IDLE → HDR → ADDR → WDATA → IDLE. Writes produce no `resp_valid`.
- Read path: IDLE → HDR → ADDR → WAIT.
  - In WAIT, the first cycle with `rx_pins[0]==1` is the start symbol; the state moves to RECV.
  - RECV samples DATA_BITS/2 symbols MSB-first into a shift register, then moves to DONE.
  - DONE loads `resp_data`, pulses `resp_valid`, and returns to IDLE.
- `rx_pins` is ignored outside WAIT and RECV. Inside RECV it is sampled unconditionally, with no framing check.
- Timeout: a WAIT cycle counter starts at 0 on entry to WAIT.
  - If TIMEOUT WAIT cycles pass with no start symbol, `timeout` pulses for one cycle and the state returns to IDLE.
  - `resp_data` is left unchanged and `resp_valid` is not asserted.
  - A start symbol arriving in the same cycle the limit is reached wins: no timeout is raised.
- Counters: the symbol counter and the timeout counter are sized to clog2 of their maximum value plus 1. Neither counter wraps.

## Timing

- Reset (`rst_n` low at a clock edge) forces, on the next cycle:
  - state = IDLE, `tx_pins` = 0, `resp_valid` = 0, `timeout` = 0, `resp_data` = 0, `req_ready` = 1.
- Reset mid-transaction aborts immediately, with no partial response and no timeout pulse.
- Let the request be accepted at edge T. Then:
  - The header appears on `tx_pins` during cycle T+1.
  - Address symbols appear during cycles T+2 … T+1+A, where A = ADDR_BITS/2.
- Write, with D = DATA_BITS/2:
  - Data symbols appear during cycles T+2+A … T+1+A+D.
  - `tx_pins` = 0 and `req_ready` = 1 during cycle T+2+A+D.
  - With defaults this is T+18, and the next request can be accepted at that edge.
- Read:
  - WAIT begins during cycle T+2+A; `tx_pins` = 0 from then on.
  - If the start symbol is sampled in cycle S, data symbols are sampled in cycles S+1 … S+D.
  - `resp_valid` = 1 and the new `resp_data` are visible in cycle S+D+1.
  - `req_ready` returns to 1 in cycle S+D+2.
- Read timeout: with WAIT starting in cycle W and no start symbol in cycles W … W+TIMEOUT−1, `timeout` = 1 in cycle W+TIMEOUT and `req_ready` = 1 in cycle W+TIMEOUT+1.
- `resp_valid` and `timeout` are never asserted together.

## Test plan

- Reset: hold `rst_n`=0 for 3 cycles while driving `req_valid`=1 and `rx_pins`=2'b11 → `tx_pins`=0, `req_ready`=1, and no pulses. Then release.
- Write: `addr`=16'hA5C3, `wdata`=16'h1234, accepted at T → `tx_pins` sequence 3, then 2,2,1,1,3,0,0,3, then 0,1,0,2,0,3,1,0 over T+1…T+17; `req_ready`=1 at T+18; no `resp_valid`.
- Read: `addr`=16'h0001; the emulator drives start 2'b01 five cycles into WAIT, then the symbols for 16'hBEEF → `tx_pins` header 2; `resp_valid` is a single pulse 9 cycles after the start; `resp_data`=16'hBEEF and is held afterwards.
- Timeout: read with `TIMEOUT`=4 and `rx_pins` held at 0 → `timeout` pulses exactly in cycle W+4; `resp_data` unchanged; the next request is accepted normally.
- Boundary: start symbol in the last allowed cycle W+TIMEOUT−1 → normal response, no `timeout`. Start in cycle W+TIMEOUT → ignored, and `timeout` pulses.
- Abort: assert `rst_n`=0 during RECV, then issue a fresh read → no stale `resp_valid`, and the header is emitted correctly.
